regfile8_onehot: RTL and testbench

- 8-entry general-purpose register file for the single-cycle datapath.
- Sits directly downstream of the 3-to-8 destination-register decoder and consumes its one-hot select vector as the write-port select.
- Provides two combinational read ports for the operand stage and one clocked write port for writeback.
- Flags malformed (non-one-hot) write selects.

---
 rtl/regfile8_onehot.sv | 48 ++++
 tb/tb_regfile8_onehot.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/regfile8_onehot.sv
// regfile8_onehot: 8x WIDTH register file, two async read ports, one-hot write port with select check.
// Optional macro RF_BYPASS_EN forwards a valid write to matching read ports in the same cycle.
module regfile8_onehot #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [7:0]       wr_sel,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [2:0]       rd_addr1,
  input  logic [2:0]       rd_addr2,
  output logic [WIDTH-1:0] rd_data1,
  output logic [WIDTH-1:0] rd_data2,
  output logic             sel_err,
  output logic [7:0]       wr_count
);
  logic [WIDTH-1:0] regs [8];
  logic sel_ok;
  logic we;
  // exactly one bit set: nonzero and clearing the lowest set bit leaves nothing
  assign sel_ok = (wr_sel != 8'd0) && ((wr_sel & (wr_sel - 8'd1)) == 8'd0);
  assign we = wr_en && sel_ok;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
      sel_err <= 1'b0;
      wr_count <= 8'd0;
    end else begin
      sel_err <= wr_en && !sel_ok;
      if (we) begin
        for (int i = 0; i < 8; i++) if (wr_sel[i]) regs[i] <= wr_data;
        wr_count <= wr_count + 8'd1;
      end
    end
  end
`ifdef RF_BYPASS_EN
  always_comb begin
    rd_data1 = (we && wr_sel[rd_addr1]) ? wr_data : regs[rd_addr1];
    rd_data2 = (we && wr_sel[rd_addr2]) ? wr_data : regs[rd_addr2];
  end
`else
  always_comb begin
    rd_data1 = regs[rd_addr1];
    rd_data2 = regs[rd_addr2];
  end
`endif
endmodule

// File: tb/tb_regfile8_onehot.sv
// tb_regfile8_onehot: vector table, hand sequences and random traffic against a behavioural model.
module tb_regfile8_onehot;
`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, wr_en = 1'b0, sel_err;
  logic [7:0] wr_sel = 8'd0, wr_count;
  logic [15:0] wr_data = 16'd0, rd_data1, rd_data2;
  logic [2:0] rd_addr1 = 3'd0, rd_addr2 = 3'd0;
  int tests = 0, fails = 0;
  logic [15:0] mregs [8];
  int mcnt;
  bit merr;

  regfile8_onehot #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_sel(wr_sel), .wr_data(wr_data),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(rd_data1), .rd_data2(rd_data2),
    .sel_err(sel_err), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit en; logic [7:0] sel; logic [15:0] data; logic [2:0] a1, a2;
    logic [15:0] e1, e2; bit eerr; logic [7:0] ecnt;
  } vec_t;
  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit onehot(input logic [7:0] s);
    return $countones(s) == 1;
  endfunction

  function automatic logic [15:0] mrd(input logic [2:0] a);
    return (BYP && wr_en && onehot(wr_sel) && wr_sel[a]) ? wr_data : mregs[a];
  endfunction

  task automatic mreset();
    for (int i = 0; i < 8; i++) mregs[i] = 16'd0;
    mcnt = 0;
    merr = 1'b0;
  endtask

  task automatic mupd();
    merr = wr_en && !onehot(wr_sel);
    if (wr_en && onehot(wr_sel)) begin
      for (int i = 0; i < 8; i++) if (wr_sel[i]) mregs[i] = wr_data;
      mcnt = (mcnt + 1) % 256;
    end
  endtask

  task automatic step(input bit en, input logic [7:0] sel, input logic [15:0] d,
                      input logic [2:0] a1, input logic [2:0] a2);
    wr_en = en; wr_sel = sel; wr_data = d; rd_addr1 = a1; rd_addr2 = a2;
    #1;
    chk("rd1_pre", rd_data1, mrd(a1));
    chk("rd2_pre", rd_data2, mrd(a2));
    @(posedge clk);
    mupd();
    #1;
    chk("sel_err", sel_err, merr);
    chk("wr_count", wr_count, mcnt[7:0]);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mreset();
    #1;
    chk("rst_rd1", rd_data1, 16'd0);
    chk("rst_rd2", rd_data2, 16'd0);
    chk("rst_err", sel_err, 1'b0);
    chk("rst_cnt", wr_count, 8'd0);
    #2 rst = 1'b0;
  endtask

  initial begin
    logic [7:0] s;
    mreset();
    for (int i = 0; i < 8; i++)
      vecs[i] = '{1'b1, 8'd1 << i, 16'h1000 + 16'(i), 3'(i), 3'd0, 16'h1000 + 16'(i), 16'h1000, 1'b0, 8'(i + 1)};
    vecs[8]  = '{1'b1, 8'h05, 16'hBEEF, 3'd0, 3'd2, 16'h1000, 16'h1002, 1'b1, 8'd8};
    vecs[9]  = '{1'b0, 8'h05, 16'hBEEF, 3'd0, 3'd2, 16'h1000, 16'h1002, 1'b0, 8'd8};
    vecs[10] = '{1'b1, 8'h00, 16'hBEEF, 3'd1, 3'd7, 16'h1001, 16'h1007, 1'b1, 8'd8};
    vecs[11] = '{1'b0, 8'h00, 16'hBEEF, 3'd1, 3'd7, 16'h1001, 16'h1007, 1'b0, 8'd8};
    vecs[12] = '{1'b1, 8'hFF, 16'h5555, 3'd4, 3'd5, 16'h1004, 16'h1005, 1'b1, 8'd8};
    vecs[13] = '{1'b1, 8'h80, 16'h7777, 3'd7, 3'd6, 16'h7777, 16'h1006, 1'b0, 8'd9};
    #3 rst = 1'b0;
    @(posedge clk); #1;
    do_reset();
    foreach (vecs[k]) begin
      wr_en = vecs[k].en; wr_sel = vecs[k].sel; wr_data = vecs[k].data;
      rd_addr1 = vecs[k].a1; rd_addr2 = vecs[k].a2;
      @(posedge clk);
      mupd();
      #1 wr_en = 1'b0;
      #1;
      chk($sformatf("vec%0d_rd1", k), rd_data1, vecs[k].e1);
      chk($sformatf("vec%0d_rd2", k), rd_data2, vecs[k].e2);
      chk($sformatf("vec%0d_err", k), sel_err, vecs[k].eerr);
      chk($sformatf("vec%0d_cnt", k), wr_count, vecs[k].ecnt);
    end
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++) begin
        rd_addr1 = 3'(a); rd_addr2 = 3'(b);
        #1;
        chk("pair_rd1", rd_data1, mregs[a]);
        chk("pair_rd2", rd_data2, mregs[b]);
      end
    @(posedge clk); #1;
    step(1'b1, 8'h08, 16'h1111, 3'd3, 3'd3);
    wr_en = 1'b1; wr_sel = 8'h08; wr_data = 16'h2222; rd_addr1 = 3'd3;
    #1;
    chk("same_cycle_pre", rd_data1, BYP ? 16'h2222 : 16'h1111);
    @(posedge clk);
    mupd();
    #1;
    chk("same_cycle_post", rd_data1, 16'h2222);
    for (int n = 0; n < 400; n++) begin
      s = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'd1 << $urandom_range(0, 7);
      step(1'($urandom_range(0, 3) != 0), s, 16'($urandom), 3'($urandom), 3'($urandom));
    end
    do_reset();
    for (int n = 0; n < 256; n++)
      step(1'b1, 8'd1 << $urandom_range(0, 7), 16'($urandom), 3'($urandom), 3'($urandom));
    chk("wrap_256", wr_count, 8'd0);
    step(1'b1, 8'h40, 16'hC0DE, 3'd6, 3'd1);
    chk("wrap_257", wr_count, 8'd1);
    wr_en = 1'b1; wr_sel = 8'h01; wr_data = 16'hAAAA; rd_addr1 = 3'd0; rst = 1'b1;
    mreset();
    @(posedge clk);
    #1 rst = 1'b0; wr_en = 1'b0;
    #1;
    chk("rstwr_r0", rd_data1, 16'd0);
    chk("rstwr_cnt", wr_count, 8'd0);
    chk("rstwr_err", sel_err, 1'b0);
    step(1'b1, 8'h01, 16'hAAAA, 3'd0, 3'd1);
    chk("post_rst_write", rd_data1, 16'hAAAA);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
